lcd_timing_gen: RTL and testbench

Parametrised RGB-parallel LCD timing generator and pixel pipeline. Derives a pixel clock enable from the system clock, sweeps programmable horizontal and vertical timing, and issues per-pixel fetch requests to an upstream pixel source. It delays sync and data-enable by a configurable fetch latency so that `lcd_db` is aligned with them, and overlays an optional bus-programmable border. It sits between the SPI-slave bus and the LCD pins, and replaces hard-coded timing in the top level.

---
 rtl/lcd_timing_gen_if.sv | 21 ++
 rtl/lcd_timing_gen.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_gen_if.sv
// Bus write port and pixel fetch port of lcd_timing_gen.
// The generator takes the slave side; the bus master / pixel source takes the master side.
interface lcd_timing_gen_if;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_wen;
   logic        pix_req;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [17:0] pix_data;

   modport master (
      output bus_addr, bus_wdata, bus_wen, pix_data,
      input  pix_req, pix_x, pix_y
   );

   modport slave (
      input  bus_addr, bus_wdata, bus_wen, pix_data,
      output pix_req, pix_x, pix_y
   );
endinterface

// File: rtl/lcd_timing_gen.sv
// RGB666 LCD timing generator with a PIPE-deep pixel fetch pipeline.
// Define LCD_BORDER_EN to build the bus-programmable border overlay.
module lcd_timing_gen #(
   parameter int          H_SYNC      = 30,
   parameter int          H_BP        = 29,
   parameter int          H_ACT       = 320,
   parameter int          H_FP        = 29,
   parameter int          V_SYNC      = 8,
   parameter int          V_BP        = 7,
   parameter int          V_ACT       = 480,
   parameter int          V_FP        = 7,
   parameter int          CLK_DIV     = 4,
   parameter int          PIPE        = 2,
   parameter int          SYNC_POL    = 0,
   parameter logic [31:0] CTRL_ADDR   = 32'hf800_1000,
   parameter logic [31:0] BORDER_ADDR = 32'hf800_1010
) (
   input  logic            clk,
   input  logic            rst,
   lcd_timing_gen_if.slave bus,
   output logic            lcd_dotclk,
   output logic            lcd_hsync,
   output logic            lcd_vsync,
   output logic            lcd_data_en,
   output logic [17:0]     lcd_db,
   output logic            frame_start,
   output logic [15:0]     frame_count
);

   localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
   localparam logic [10:0]      H_LAST     = 11'(H_TOT - 1);
   localparam logic [10:0]      V_LAST     = 11'(V_TOT - 1);
   localparam logic [10:0]      H_SYNC_END = 11'(H_SYNC);
   localparam logic [10:0]      V_SYNC_END = 11'(V_SYNC);
   localparam logic [10:0]      H_FIRST    = 11'(H_SYNC + H_BP);
   localparam logic [10:0]      H_LAST_ACT = 11'(H_SYNC + H_BP + H_ACT - 1);
   localparam logic [10:0]      V_FIRST    = 11'(V_SYNC + V_BP);
   localparam logic [10:0]      V_LAST_ACT = 11'(V_SYNC + V_BP + V_ACT - 1);
   localparam logic             SYNC_ON    = 1'(SYNC_POL);

   // One pipeline tap: sync and enable flags travelling alongside the fetch.
   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
      logic brd;
   } tap_t;

   logic                enable_q, enable_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [10:0]         hpos_q, hpos_d;
   logic [10:0]         vpos_q, vpos_d;
   tap_t [PIPE-1:0]     pipe_q, pipe_d;
   logic [15:0]         frame_count_q, frame_count_d;
   logic                dotclk_q, dotclk_d;
   logic                hsync_q, hsync_d;
   logic                vsync_q, vsync_d;
   logic                de_q, de_d;
   logic [17:0]         db_q, db_d;

   logic                ce;
   logic                active;
   logic                edge_hit;
   logic [17:0]         border_col;
   logic [10:0]         hrel, vrel;
   tap_t                tap_in, tap_out;
   logic                unused_bits;

   // Gating with rst keeps the combinational pulses low while reset is held.
   assign ce          = enable_q && (div_q == '0) && !rst;
   assign active      = (hpos_q >= H_FIRST) && (hpos_q <= H_LAST_ACT) &&
                        (vpos_q >= V_FIRST) && (vpos_q <= V_LAST_ACT);
   assign frame_start = ce && (hpos_q == '0) && (vpos_q == '0);

   assign hrel        = hpos_q - H_FIRST;
   assign vrel        = vpos_q - V_FIRST;
   assign bus.pix_req = ce && active;
   assign bus.pix_x   = hrel[9:0];
   assign bus.pix_y   = vrel[9:0];

   assign tap_in.hs   = hpos_q < H_SYNC_END;
   assign tap_in.vs   = vpos_q < V_SYNC_END;
   assign tap_in.act  = active;
   assign tap_in.brd  = active && edge_hit;
   assign tap_out     = pipe_q[PIPE-1];

`ifdef LCD_BORDER_EN
   logic [17:0] border_q, border_d;

   always_comb begin
      border_d = border_q;
      if (bus.bus_wen && (bus.bus_addr == BORDER_ADDR)) border_d = bus.bus_wdata[17:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) border_q <= 18'h3ffff;
      else     border_q <= border_d;
   end

   assign border_col  = border_q;
   assign edge_hit    = (hpos_q == H_FIRST) || (hpos_q == H_LAST_ACT) ||
                        (vpos_q == V_FIRST) || (vpos_q == V_LAST_ACT);
   assign unused_bits = ^{bus.bus_wdata[31:18], hrel[10], vrel[10]};
`else
   assign border_col  = '0;
   assign edge_hit    = 1'b0;
   assign unused_bits = ^{bus.bus_wdata[31:1], BORDER_ADDR, hrel[10], vrel[10]};
`endif

   // NOTE: every next-state value gets its default first so no latch is inferred.
   always_comb begin
      enable_d      = enable_q;
      div_d         = div_q;
      hpos_d        = hpos_q;
      vpos_d        = vpos_q;
      pipe_d        = pipe_q;
      frame_count_d = frame_count_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      de_d          = de_q;
      db_d          = db_q;

      if (bus.bus_wen && (bus.bus_addr == CTRL_ADDR)) enable_d = bus.bus_wdata[0];

      if (enable_q) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

      if (ce) begin
         if (hpos_q == H_LAST) begin
            hpos_d = '0;
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 11'd1;
         end else begin
            hpos_d = hpos_q + 11'd1;
         end
         pipe_d[0] = tap_in;
         for (int i = 1; i < PIPE; i++) pipe_d[i] = pipe_q[i-1];
         // The pixel requested PIPE pixel periods ago is on pix_data in this cycle.
         hsync_d = tap_out.hs ? SYNC_ON : ~SYNC_ON;
         vsync_d = tap_out.vs ? SYNC_ON : ~SYNC_ON;
         de_d    = tap_out.act;
         db_d    = !tap_out.act ? '0 : (tap_out.brd ? border_col : bus.pix_data);
      end

      if (frame_start) frame_count_d = frame_count_q + 16'd1;

      if (!enable_d) begin
         div_d         = '0;
         hpos_d        = '0;
         vpos_d        = '0;
         pipe_d        = '0;
         frame_count_d = '0;
         hsync_d       = ~SYNC_ON;
         vsync_d       = ~SYNC_ON;
         de_d          = 1'b0;
         db_d          = '0;
      end

      dotclk_d = enable_d && (div_d >= DIV_HALF);
   end

   // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_q      <= 1'b1;
         div_q         <= '0;
         hpos_q        <= '0;
         vpos_q        <= '0;
         pipe_q        <= '0;
         frame_count_q <= '0;
         dotclk_q      <= 1'b0;
         hsync_q       <= ~SYNC_ON;
         vsync_q       <= ~SYNC_ON;
         de_q          <= 1'b0;
         db_q          <= '0;
      end else begin
         enable_q      <= enable_d;
         div_q         <= div_d;
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         pipe_q        <= pipe_d;
         frame_count_q <= frame_count_d;
         dotclk_q      <= dotclk_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         db_q          <= db_d;
      end
   end

   assign lcd_dotclk  = dotclk_q;
   assign lcd_hsync   = hsync_q;
   assign lcd_vsync   = vsync_q;
   assign lcd_data_en = de_q;
   assign lcd_db      = db_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a small 23x7-pixel frame, CLK_DIV=4, PIPE=3.
// Expected values follow the LCD_BORDER_EN setting of the build.
module tb_lcd_timing_gen;

   localparam logic [31:0] CTRL_ADDR   = 32'hf800_1000;
   localparam logic [31:0] BORDER_ADDR = 32'hf800_1010;

`ifdef LCD_BORDER_EN
   localparam bit BRD = 1'b1;
`else
   localparam bit BRD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lcd_dotclk, lcd_hsync, lcd_vsync, lcd_data_en, frame_start;
   logic [17:0] lcd_db;
   logic [15:0] frame_count;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int base  = 0;

   lcd_timing_gen_if bus ();

   always #5 clk = ~clk;

   lcd_timing_gen #(
      .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(10),
      .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1),
      .CLK_DIV(4), .PIPE(3), .SYNC_POL(0),
      .CTRL_ADDR(CTRL_ADDR), .BORDER_ADDR(BORDER_ADDR)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .lcd_dotclk(lcd_dotclk), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
      .lcd_data_en(lcd_data_en), .lcd_db(lcd_db),
      .frame_start(frame_start), .frame_count(frame_count)
   );

   // Pixel source: returns {y,x} of each request three pixel periods later.
   logic        prev_dot = 1'b0;
   logic [17:0] src_q [3] = '{default: '0};

   always @(posedge clk) begin
      if (prev_dot && !lcd_dotclk) begin
         src_q[0] <= {bus.pix_y[8:0], bus.pix_x[8:0]};
         src_q[1] <= src_q[0];
         src_q[2] <= src_q[1];
      end
      prev_dot <= lcd_dotclk;
   end

   assign bus.pix_data = src_q[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic to_cyc(input int c);
      while (cyc < c) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic to_rel(input int c);
      to_cyc(base + c);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.bus_addr  = a;
      bus.bus_wdata = d;
      bus.bus_wen   = 1'b1;
      @(negedge clk);
      cyc++;
      bus.bus_wen   = 1'b0;
   endtask

   function automatic logic [31:0] edge_px(input logic [17:0] v);
      return BRD ? 32'h2a555 : {14'd0, v};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int hs_low, vs_low, de_hi, db_bad;
      bus.bus_addr  = '0;
      bus.bus_wdata = '0;
      bus.bus_wen   = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_dotclk", lcd_dotclk, 0);
      check("rst_hsync", lcd_hsync, 1);
      check("rst_vsync", lcd_vsync, 1);
      check("rst_de", lcd_data_en, 0);
      check("rst_db", lcd_db, 0);
      check("rst_pix_req", bus.pix_req, 0);
      check("rst_fs", frame_start, 0);
      check("rst_fc", frame_count, 0);

      rst = 1'b0;
      #1;
      cyc = 0;
      check("fs_first_ce", frame_start, 1);
      check("fc_first_ce", frame_count, 0);
      to_cyc(1);
      check("fc_after_first", frame_count, 1);
      check("fs_one_clk", frame_start, 0);
      for (int c = 1; c <= 8; c++) begin
         to_cyc(c);
         check("dotclk_phase", lcd_dotclk, ((c % 4) >= 2) ? 32'd1 : 32'd0);
      end

      to_cyc(9);
      bus_write(BORDER_ADDR, 32'h0002_a555);
      check("hsync_pipe_fill", lcd_hsync, 1);

      to_cyc(14);  check("hsync_p0", lcd_hsync, 0); check("vsync_l0", lcd_vsync, 0);
      to_cyc(18);  check("hsync_p1", lcd_hsync, 0);
      to_cyc(22);  check("hsync_p2", lcd_hsync, 1);
      to_cyc(102); check("hsync_p22", lcd_hsync, 1); check("vsync_l0_end", lcd_vsync, 0);
      to_cyc(106); check("hsync_l1", lcd_hsync, 0); check("vsync_l1", lcd_vsync, 1);

      to_cyc(204); check("req_first", bus.pix_req, 1);
      check("req_x0", bus.pix_x, 0); check("req_y0", bus.pix_y, 0);
      to_cyc(205); check("req_one_clk", bus.pix_req, 0);
      to_cyc(214); check("de_before", lcd_data_en, 0); check("db_before", lcd_db, 0);
      to_cyc(218); check("de_first", lcd_data_en, 1); check("db_y0x0", lcd_db, edge_px(18'h0));
      to_cyc(222); check("db_y0x1", lcd_db, edge_px(18'h1));
      to_cyc(232); check("req_last", bus.pix_req, 1); check("req_x7", bus.pix_x, 7);
      to_cyc(236); check("req_after_last", bus.pix_req, 0);
      to_cyc(246); check("db_y0x7", lcd_db, edge_px(18'h7));
      to_cyc(300); check("req_x1", bus.pix_x, 1); check("req_y1", bus.pix_y, 1);
      to_cyc(310); check("db_y1x0", lcd_db, edge_px(18'h200));
      to_cyc(314); check("de_y1x1", lcd_data_en, 1); check("db_y1x1", lcd_db, 32'h201);
      to_cyc(338); check("db_y1x7", lcd_db, edge_px(18'h207));
      to_cyc(342); check("de_after", lcd_data_en, 0); check("db_after", lcd_db, 0);
      to_cyc(414); check("db_y2x3", lcd_db, 32'h403);
      to_cyc(510); check("db_y3x4", lcd_db, edge_px(18'h604));

      to_cyc(644); check("fs_frame2", frame_start, 1);
      to_cyc(645); check("fc_frame2", frame_count, 2);

      hs_low = 0; vs_low = 0; de_hi = 0; db_bad = 0;
      for (int c = 645; c < 645 + 644; c++) begin
         to_cyc(c);
         if (!lcd_hsync) hs_low++;
         if (!lcd_vsync) vs_low++;
         if (lcd_data_en) de_hi++;
         if (!lcd_data_en && (lcd_db != '0)) db_bad++;
      end
      check("hsync_low_per_frame", hs_low, 56);
      check("vsync_low_per_frame", vs_low, 92);
      check("de_high_per_frame", de_hi, 128);
      check("db_outside_de", db_bad, 0);

      to_cyc(1300);
      bus_write(32'hf800_1004, 32'h0);
      to_cyc(1302); check("fc_unknown_addr", frame_count, 3);
      to_cyc(1602); check("de_pre_disable", lcd_data_en, 1); check("db_pre_disable", lcd_db, 32'h201);
      bus_write(CTRL_ADDR, 32'h0);
      check("dis_dotclk", lcd_dotclk, 0);
      check("dis_hsync", lcd_hsync, 1);
      check("dis_vsync", lcd_vsync, 1);
      check("dis_de", lcd_data_en, 0);
      check("dis_db", lcd_db, 0);
      check("dis_fc", frame_count, 0);
      to_cyc(1604); check("dis_pix_req", bus.pix_req, 0); check("dis_fs", frame_start, 0);

      to_cyc(1620);
      bus_write(CTRL_ADDR, 32'h1);
      base = cyc;
      check("en_fs", frame_start, 1);
      check("en_fc_before", frame_count, 0);
      to_rel(1);   check("en_fc_after", frame_count, 1);
      to_rel(2);   check("en_dotclk", lcd_dotclk, 1);
      to_rel(100);
      force dut.frame_count_q = 16'hffff;
      to_rel(101);
      release dut.frame_count_q;
      to_rel(200); check("fc_held_ffff", frame_count, 32'hffff);
      to_rel(314); check("en_db_y1x1", lcd_db, 32'h201);
      to_rel(644); check("wrap_fs", frame_start, 1); check("wrap_fc_before", frame_count, 32'hffff);
      to_rel(645); check("wrap_fc_after", frame_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
